inv_lower_2_gram: RTL and testbench

INV_LOWER_2_GRAM -- requirements
Module: inv_lower_2_gram

---
 rtl/inv_lower_2_gram.sv | 140 ++++++++++++++
 tb/tb_inv_lower_2_gram.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_lower_2_gram.sv
// Computes P = Z^T * Z for a 2x2 lower-triangular Q16.16 factor using one shared multiplier.
// Optional build macro INV_LOWER_2_GRAM_SATURATE_EN clamps products and the P_11 sum on overflow.
module inv_lower_2_gram (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [95:0] Z,
    input  logic        Z_valid,
    output logic [95:0] P,
    output logic        P_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_M1,
        S_M2,
        S_M3,
        S_M4,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_zv_prev;
    logic               w_capture;
    logic signed [31:0] r_z11;
    logic signed [31:0] r_z21;
    logic signed [31:0] r_z22;
    logic signed [31:0] r_acc;
    logic signed [31:0] r_p21;
    logic signed [31:0] r_p22;
    logic        [95:0] r_p;
    logic               r_p_valid;

    logic signed [31:0] w_op_a;
    logic signed [31:0] w_op_b;
    logic signed [63:0] w_prod;
    logic signed [31:0] w_prod_q;
    logic signed [31:0] w_sum;
    logic               w_prod_unused;

    assign w_capture = (r_state == S_IDLE) && Z_valid && !r_zv_prev;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_capture) w_state_next = S_M1;
            S_M1:   w_state_next = S_M2;
            S_M2:   w_state_next = S_M3;
            S_M3:   w_state_next = S_M4;
            S_M4:   w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The single multiplier sees a different operand pair in each compute state.
    always_comb begin
        w_op_a = r_z11;
        w_op_b = r_z11;
        case (r_state)
            S_M2: begin
                w_op_a = r_z21;
                w_op_b = r_z21;
            end
            S_M3: begin
                w_op_a = r_z21;
                w_op_b = r_z22;
            end
            S_M4: begin
                w_op_a = r_z22;
                w_op_b = r_z22;
            end
            default: begin
                w_op_a = r_z11;
                w_op_b = r_z11;
            end
        endcase
    end

    assign w_prod = w_op_a * w_op_b;

    // Bits [47:16] of the Q32.32 product are the Q16.16 result; dropping the low bits floors it.
`ifdef INV_LOWER_2_GRAM_SATURATE_EN
    logic        w_prod_ovf;
    logic [32:0] w_sum_full;

    assign w_prod_ovf = (w_prod[63:47] != {17{w_prod[63]}});
    assign w_prod_q   = w_prod_ovf ? (w_prod[63] ? 32'sh8000_0000 : 32'sh7FFF_FFFF)
                                   : w_prod[47:16];
    assign w_sum_full = {r_acc[31], r_acc} + {w_prod_q[31], w_prod_q};
    assign w_sum      = (w_sum_full[32] != w_sum_full[31])
                      ? (w_sum_full[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF)
                      : w_sum_full[31:0];
`else
    assign w_prod_q = w_prod[47:16];
    assign w_sum    = r_acc + w_prod_q;
`endif

    assign w_prod_unused = ^{w_prod[63:48], w_prod[15:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_zv_prev <= 1'b0;
            r_z11     <= '0;
            r_z21     <= '0;
            r_z22     <= '0;
            r_acc     <= '0;
            r_p21     <= '0;
            r_p22     <= '0;
            r_p       <= '0;
            r_p_valid <= 1'b0;
        end else if (clk_en) begin
            // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
            r_zv_prev <= Z_valid;
            r_state   <= w_state_next;
            r_p_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_capture) {r_z22, r_z21, r_z11} <= Z;
                S_M1:   r_acc <= w_prod_q;
                S_M2:   r_acc <= w_sum;
                S_M3:   r_p21 <= w_prod_q;
                S_M4:   r_p22 <= w_prod_q;
                S_DONE: begin
                    r_p       <= {r_p22, r_p21, r_acc};
                    r_p_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign P       = r_p;
    assign P_valid = r_p_valid;
    assign busy    = (r_state != S_IDLE) || r_p_valid;

endmodule

// File: tb/tb_inv_lower_2_gram.sv
// Directed bench for inv_lower_2_gram: hand-computed Gram products, latency, edge detect, stall and reset.
module tb_inv_lower_2_gram;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [95:0] Z;
    logic        Z_valid;
    logic [95:0] P;
    logic        P_valid;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    inv_lower_2_gram dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .Z       (Z),
        .Z_valid (Z_valid),
        .P       (P),
        .P_valid (P_valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] z11, input logic [31:0] z21, input logic [31:0] z22);
        Z       = {z22, z21, z11};
        Z_valid = 1'b1;
        step();
        Z_valid = 1'b0;
    endtask

    task automatic run_until_valid(input int max_edges, output int n);
        n = 0;
        while (P_valid !== 1'b1 && n < max_edges) begin
            step();
            n++;
        end
    endtask

    task automatic count_pulses(input int n_steps, output int cnt);
        cnt = 0;
        for (int i = 0; i < n_steps; i++) begin
            step();
            if (P_valid === 1'b1) cnt++;
        end
    endtask

    task automatic run_vector(input string tag,
                              input logic [31:0] z11, input logic [31:0] z21, input logic [31:0] z22,
                              input logic [31:0] p11, input logic [31:0] p21, input logic [31:0] p22);
        int n;
        launch(z11, z21, z22);
        check({tag, "_busy_after_capture"}, {95'd0, busy}, 96'd1);
        run_until_valid(20, n);
        check({tag, "_latency"}, 96'(n), 96'd5);
        check({tag, "_P"}, P, {p22, p21, p11});
        check({tag, "_busy_at_valid"}, {95'd0, busy}, 96'd1);
        step();
        check({tag, "_pvalid_one_cycle"}, {95'd0, P_valid}, 96'd0);
        check({tag, "_busy_cleared"}, {95'd0, busy}, 96'd0);
        check({tag, "_P_held"}, P, {p22, p21, p11});
    endtask

    initial begin
        int n;
        int cnt;
        int cnt2;
        logic [31:0] ovf_p11;

        rst     = 1'b0;
        clk_en  = 1'b1;
        Z       = '0;
        Z_valid = 1'b0;
        #3;
        check("reset_P", P, 96'd0);
        check("reset_P_valid", {95'd0, P_valid}, 96'd0);
        check("reset_busy", {95'd0, busy}, 96'd0);
        step();
        rst = 1'b1;
        step();
        step();
        check("idle_no_valid", {95'd0, P_valid}, 96'd0);

        run_vector("identity", 32'h0001_0000, 32'h0000_0000, 32'h0001_0000,
                   32'h0001_0000, 32'h0000_0000, 32'h0001_0000);
        run_vector("scaled", 32'h0002_0000, 32'h0000_8000, 32'h0000_4000,
                   32'h0004_4000, 32'h0000_2000, 32'h0000_1000);
        run_vector("negative", 32'h0001_0000, 32'hFFFF_8000, 32'h0001_0000,
                   32'h0001_4000, 32'hFFFF_8000, 32'h0001_0000);
        // -1 ulp times +1 ulp floors to -1 ulp rather than truncating to zero.
        run_vector("floor", 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001,
                   32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
`ifdef INV_LOWER_2_GRAM_SATURATE_EN
        ovf_p11 = 32'h7FFF_FFFF;
`else
        ovf_p11 = 32'h0000_0000;
`endif
        run_vector("overflow", 32'h0100_0000, 32'h0000_0000, 32'h0000_0000,
                   ovf_p11, 32'h0000_0000, 32'h0000_0000);

        // Back-to-back: a new edge in the IDLE cycle that carries P_valid starts the next job.
        launch(32'h0001_0000, 32'h0000_0000, 32'h0001_0000);
        run_until_valid(20, n);
        check("b2b_first_latency", 96'(n), 96'd5);
        Z       = {32'h0000_4000, 32'h0000_8000, 32'h0002_0000};
        Z_valid = 1'b1;
        step();
        Z_valid = 1'b0;
        check("b2b_second_captured", {95'd0, busy}, 96'd1);
        run_until_valid(20, n);
        check("b2b_second_latency", 96'(n), 96'd5);
        check("b2b_second_P", P, {32'h0000_1000, 32'h0000_2000, 32'h0004_4000});
        step();

        // Held-high Z_valid yields exactly one computation.
        Z       = {32'h0000_8000, 32'h0001_8000, 32'h0003_0000};
        Z_valid = 1'b1;
        count_pulses(12, cnt);
        Z_valid = 1'b0;
        count_pulses(10, cnt2);
        check("held_one_pulse", 96'(cnt + cnt2), 96'd1);
        check("held_P", P, {32'h0000_4000, 32'h0000_C000, 32'h000B_4000});

        // A fresh edge arriving in M2 is ignored and does not disturb the captured operands.
        launch(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000);
        step();
        Z       = {32'h0005_0000, 32'h0005_0000, 32'h0005_0000};
        Z_valid = 1'b1;
        step();
        Z_valid = 1'b0;
        count_pulses(12, cnt);
        check("m2_edge_one_pulse", 96'(cnt), 96'd1);
        check("m2_edge_P", P, {32'h0001_0000, 32'hFFFE_0000, 32'h0005_0000});
        check("m2_edge_idle", {95'd0, busy}, 96'd0);

        // Three disabled edges in M2 stretch latency from 5 to 8 edges.
        launch(32'h0002_0000, 32'h0000_8000, 32'h0000_4000);
        step();
        clk_en = 1'b0;
        step();
        step();
        step();
        check("stall_busy", {95'd0, busy}, 96'd1);
        check("stall_no_valid", {95'd0, P_valid}, 96'd0);
        clk_en = 1'b1;
        run_until_valid(20, n);
        check("stall_latency", 96'(n + 4), 96'd8);
        check("stall_P", P, {32'h0000_1000, 32'h0000_2000, 32'h0004_4000});
        clk_en = 1'b0;
        step();
        step();
        check("stall_pvalid_frozen", {95'd0, P_valid}, 96'd1);
        clk_en = 1'b1;
        step();
        check("stall_pvalid_drop", {95'd0, P_valid}, 96'd0);

        // Reset in M3 abandons the job; no result afterwards.
        launch(32'h0001_0000, 32'hFFFF_8000, 32'h0001_0000);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        check("midreset_P", P, 96'd0);
        check("midreset_P_valid", {95'd0, P_valid}, 96'd0);
        check("midreset_busy", {95'd0, busy}, 96'd0);
        step();
        rst = 1'b1;
        count_pulses(10, cnt);
        check("midreset_no_valid", 96'(cnt), 96'd0);

        // Z_valid already high across reset release counts as a new edge.
        Z_valid = 1'b1;
        rst     = 1'b0;
        step();
        check("held_reset_busy", {95'd0, busy}, 96'd0);
        rst = 1'b1;
        step();
        check("post_reset_capture", {95'd0, busy}, 96'd1);
        run_until_valid(20, n);
        check("post_reset_latency", 96'(n), 96'd5);
        check("post_reset_P", P, {32'h0001_0000, 32'hFFFF_8000, 32'h0001_4000});
        Z_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
